data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Parameters
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width in bits.
REQ-003 SHALL have parameter NUM_SETS, default 8, number of sets; power of 2, minimum 2.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counters.

Interface
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit, reset; synchronous, active-high.
REQ-007 SHALL have port rd_en_i, input, 1 bit, CPU load request.
REQ-008 SHALL have port wr_en_i, input, 1 bit, CPU store request.
REQ-009 SHALL have port addr_i, input, ADDR_WIDTH bits, CPU byte address; word-aligned.
REQ-010 SHALL have port wdata_i, input, DATA_WIDTH bits, CPU store data.
REQ-011 SHALL have port rdata_o, output, DATA_WIDTH bits, CPU load data.
REQ-012 SHALL have port stall_o, output, 1 bit, CPU must hold its request and PC while high.
REQ-013 SHALL have port mem_req_o, output, 1 bit, backing-memory request.
REQ-014 SHALL have port mem_we_o, output, 1 bit, backing-memory write qualifier.
REQ-015 SHALL have port mem_addr_o, output, ADDR_WIDTH bits, backing-memory address.
REQ-016 SHALL have port mem_wdata_o, output, DATA_WIDTH bits, backing-memory write data.
REQ-017 SHALL have port mem_rdata_i, input, DATA_WIDTH bits, backing-memory read data.
REQ-018 SHALL have port mem_ack_i, input, 1 bit, one-cycle completion pulse; mem_rdata_i is valid in the ack cycle.
REQ-019 SHALL have port hit_cnt_o, output, CNT_WIDTH bits, count of read hits.
REQ-020 SHALL have port miss_cnt_o, output, CNT_WIDTH bits, count of read misses.

Function
REQ-021 SHALL be 2-way set-associative with a one-word line: index = addr_i[2+log2(NUM_SETS)-1:2], tag = remaining upper bits; addr_i[1:0] ignored.
REQ-022 SHALL hold per-way valid, tag and data arrays, plus one LRU bit per set.
REQ-023 SHALL implement FSM states IDLE, RD_MISS and WR_THRU.
REQ-024 SHALL, in IDLE on rd_en_i with a tag hit, drive rdata_o combinationally from the hit way in the same cycle, hold stall_o low, mark the other way as LRU, and increment hit_cnt_o.
REQ-025 SHALL, in IDLE on rd_en_i with a miss, raise stall_o combinationally in that cycle, increment miss_cnt_o, and enter RD_MISS.
REQ-026 SHALL, in RD_MISS, hold mem_req_o=1, mem_we_o=0 and mem_addr_o={addr_i[ADDR_WIDTH-1:2],2'b00} with stall_o=1 until mem_ack_i.
REQ-027 SHALL, on mem_ack_i in RD_MISS, fill the victim way (way 0 if invalid, else way 1 if invalid, else the LRU way), mark the filled way MRU and return to IDLE.
REQ-028 SHALL count the request that caused a refill as a hit when it is re-presented in the following cycle; the bench SHALL expect a miss followed by a hit for it.
REQ-029 SHALL, in IDLE on wr_en_i, update the data of a hitting way and mark it MRU, leave the cache unchanged on a miss (no write-allocate), raise stall_o and enter WR_THRU.
REQ-030 SHALL, in WR_THRU, hold mem_req_o=1, mem_we_o=1 and mem_wdata_o=wdata_i, with stall_o=1, until mem_ack_i, then return to IDLE with stall_o low in the next cycle.
REQ-031 SHALL treat rd_en_i and wr_en_i both high as a write.
REQ-032 SHALL, with no request in IDLE, drive stall_o=0 and mem_req_o=0; rdata_o is don't-care.
REQ-033 SHALL saturate both counters at all-ones without wrapping.
REQ-034 SHALL ignore mem_ack_i while in IDLE.

Reset
REQ-035 SHALL, when rst_i=1 at a clock edge, clear all valid and LRU bits, set the state to IDLE and zero both counters; tag and data arrays are not reset.
REQ-036 SHALL, after reset, drive stall_o=0, mem_req_o=0, mem_we_o=0, hit_cnt_o=0 and miss_cnt_o=0.
REQ-037 SHALL, on reset during RD_MISS or WR_THRU, abandon the transaction, write no line, and drop mem_req_o in the following cycle.

Verification
REQ-038 SHALL cover cold read: after reset, read 0x100 with mem_ack_i 3 cycles later returning 0xDEADBEEF -> stall_o high for 4 cycles, then rdata_o=0xDEADBEEF with stall_o=0, miss_cnt_o=1 and hit_cnt_o=1.
REQ-039 SHALL cover LRU eviction with NUM_SETS=8: read 0x000, then 0x020, then 0x000, then 0x040 (all index 0) -> 0x020 is evicted, so a re-read of 0x000 hits and a re-read of 0x020 misses.
REQ-040 SHALL cover write-through hit: cache 0x004, then write 0x55 to it -> mem_we_o=1 with mem_wdata_o=0x55 until ack, and a subsequent read returns 0x55 as a hit.
REQ-041 SHALL cover write miss: write 0x77 to uncached 0x008 -> backing-memory write occurs, and the next read of 0x008 is a miss.
REQ-042 SHALL cover reset mid-miss: assert rst_i in the second RD_MISS cycle -> mem_req_o=0 the next cycle, counters=0, and a re-read of the same address misses.
REQ-043 SHALL cover counter saturation with CNT_WIDTH=4: perform 20 hits -> hit_cnt_o holds 0xF.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: 2-way set-associative, write-through, no-write-allocate data
// cache with one-word lines, a per-set LRU bit and saturating hit/miss
// counters.
//
// State | Meaning
// IDLE    | serving CPU requests; read hits complete in the same cycle
// RD_MISS | waiting for backing memory to return the missing word
// WR_THRU | waiting for backing memory to accept a store
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   rd_en_i, wr_en_i      CPU load / store request (both high = store)
//   addr_i, wdata_i       CPU byte address (word aligned) and store data
//   rdata_o, stall_o      CPU load data, CPU hold request
//   mem_req_o, mem_we_o   backing-memory request and write qualifier
//   mem_addr_o            backing-memory word address
//   mem_wdata_o           backing-memory write data
//   mem_rdata_i           backing-memory read data, valid with mem_ack_i
//   mem_ack_i             one-cycle completion pulse
//   hit_cnt_o, miss_cnt_o saturating read hit / miss counters
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SETS   = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_en_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state;

  logic [NUM_SETS-1:0]   valid0, valid1;
  logic [NUM_SETS-1:0]   lru;            // 1 = way 1 is least recently used
  logic [TAG_W-1:0]      tag0  [NUM_SETS];
  logic [TAG_W-1:0]      tag1  [NUM_SETS];
  logic [DATA_WIDTH-1:0] data0 [NUM_SETS];
  logic [DATA_WIDTH-1:0] data1 [NUM_SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit0, hit1, hit, victim;
  logic             fill_en, wr_hit_en;
  logic             addr_lsb_unused;

  assign idx = addr_i[2 +: IDX_W];
  assign tag = addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign addr_lsb_unused = ^addr_i[1:0];

  assign hit0 = valid0[idx] && (tag0[idx] == tag);
  assign hit1 = valid1[idx] && (tag1[idx] == tag);
  assign hit  = hit0 || hit1;

  // Empty ways are filled in order before any replacement happens.
  assign victim = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);

  assign rdata_o = hit1 ? data1[idx] : data0[idx];

  always_comb begin
    stall_o = 1'b1;
    if (state == IDLE)
      stall_o = wr_en_i || (rd_en_i && !hit);
  end

  assign mem_req_o   = (state != IDLE);
  assign mem_we_o    = (state == WR_THRU);
  assign mem_addr_o  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata_o = wdata_i;

  // Array writes are gated by reset so an abandoned refill leaves no line.
  assign fill_en   = !rst_i && (state == RD_MISS) && mem_ack_i;
  assign wr_hit_en = !rst_i && (state == IDLE) && wr_en_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      valid0     <= '0;
      valid1     <= '0;
      lru        <= '0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en_i) begin
            if (hit) lru[idx] <= hit0;
            state <= WR_THRU;
          end else if (rd_en_i) begin
            if (hit) begin
              lru[idx] <= hit0;
              if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
            end else begin
              if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
              state <= RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (mem_ack_i) begin
            if (victim) valid1[idx] <= 1'b1;
            else        valid0[idx] <= 1'b1;
            lru[idx] <= ~victim;
            state    <= IDLE;
          end
        end
        WR_THRU: begin
          if (mem_ack_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      if (victim) begin
        tag1[idx]  <= tag;
        data1[idx] <= mem_rdata_i;
      end else begin
        tag0[idx]  <= tag;
        data0[idx] <= mem_rdata_i;
      end
    end else if (wr_hit_en) begin
      if (hit0)      data0[idx] <= wdata_i;
      else if (hit1) data1[idx] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed bench for data_cache. Stimulus tasks push the
// expected load data and expected backing-memory transactions into queues;
// a negedge monitor pops and compares whenever the DUT returns load data or
// completes a memory transaction.
module tb_data_cache;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en, wr_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic          stall, mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  data_cache #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SETS(NS), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .wr_en_i(wr_en),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  typedef struct packed {
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
  } mem_exp_t;

  mem_exp_t      mq[$];
  logic [DW-1:0] rq[$];
  mem_exp_t      me;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: load data whenever a load completes, memory fields at each ack.
  always @(negedge clk) begin
    if (rd_en && !wr_en && !stall) begin
      if (rq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rdata_unexpected: actual %0h required none", rdata);
      end else begin
        chk("rdata", rdata, rq.pop_front());
      end
    end
    if (mem_req && mem_ack) begin
      if (mq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mem_unexpected: actual addr %0h required none", mem_addr);
      end else begin
        me = mq.pop_front();
        chk("mem_we", {31'b0, mem_we}, {31'b0, me.e_we});
        chk("mem_addr", mem_addr, me.e_addr);
        if (me.e_we) chk("mem_wdata", mem_wdata, me.e_wdata);
      end
    end
  end

  task automatic do_reset(input bit check);
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    if (check) begin
      @(negedge clk);
      chk("rst_stall", {31'b0, stall}, 0);
      chk("rst_mem_req", {31'b0, mem_req}, 0);
      chk("rst_mem_we", {31'b0, mem_we}, 0);
      chk("rst_hit_cnt", {28'b0, hit_cnt}, 0);
      chk("rst_miss_cnt", {28'b0, miss_cnt}, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_cnt(input int h, input int m);
    chk("hit_cnt", {28'b0, hit_cnt}, h);
    chk("miss_cnt", {28'b0, miss_cnt}, m);
  endtask

  // Load: on a miss the request is held through the refill and re-presented
  // in the cycle after ack, where it completes as a hit.
  task automatic do_rd(input logic [31:0] a, input logic [31:0] d, input bit exp_hit,
                       input int ack_after);
    int stalls;
    stalls = 0;
    addr = a; rd_en = 1'b1;
    rq.push_back(d);
    if (exp_hit) begin
      @(negedge clk);
      chk("hit_stall", {31'b0, stall}, 0);
    end else begin
      mq.push_back('{e_we: 1'b0, e_addr: {a[31:2], 2'b00}, e_wdata: 32'h0});
      for (int c = 0; c <= ack_after; c++) begin
        if (c == ack_after) begin
          mem_ack = 1'b1;
          mem_rdata = d;
        end
        @(negedge clk);
        if (stall) stalls++;
        if (c > 0) begin
          chk("rdmiss_req", {31'b0, mem_req}, 1);
          chk("rdmiss_we", {31'b0, mem_we}, 0);
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;
      end
      @(negedge clk);
      chk("refill_stall", {31'b0, stall}, 0);
      chk("miss_stall_cycles", stalls, ack_after + 1);
    end
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input int ack_after,
                       input bit also_rd);
    int stalls;
    stalls = 0;
    addr = a; wdata = d; wr_en = 1'b1; rd_en = also_rd;
    mq.push_back('{e_we: 1'b1, e_addr: {a[31:2], 2'b00}, e_wdata: d});
    for (int c = 0; c <= ack_after; c++) begin
      if (c == ack_after) mem_ack = 1'b1;
      @(negedge clk);
      if (stall) stalls++;
      if (c > 0) begin
        chk("wr_req", {31'b0, mem_req}, 1);
        chk("wr_we", {31'b0, mem_we}, 1);
        chk("wr_wdata", mem_wdata, d);
      end
      @(posedge clk);
      #1 mem_ack = 1'b0;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk("wr_done_stall", {31'b0, stall}, 0);
    chk("wr_done_req", {31'b0, mem_req}, 0);
    chk("wr_stall_cycles", stalls, ack_after + 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; mem_ack = 1'b0;
    addr = '0; wdata = '0; mem_rdata = '0;
    @(posedge clk);
    #1;
    do_reset(1'b1);

    // Cold read: 4 stall cycles, then the re-presented load hits.
    do_rd(32'h100, 32'hDEADBEEF, 1'b0, 3);
    chk_cnt(1, 1);

    // LRU eviction within set 0.
    do_reset(1'b0);
    do_rd(32'h000, 32'hA0A0_0001, 1'b0, 2);
    do_rd(32'h020, 32'hB0B0_0002, 1'b0, 1);
    do_rd(32'h000, 32'hA0A0_0001, 1'b1, 0);
    do_rd(32'h040, 32'hC0C0_0003, 1'b0, 2);
    do_rd(32'h000, 32'hA0A0_0001, 1'b1, 0);
    do_rd(32'h020, 32'hB0B0_0004, 1'b0, 1);
    chk_cnt(6, 4);

    // Write-through hit, then a store with both enables high.
    do_reset(1'b0);
    do_rd(32'h004, 32'h11, 1'b0, 1);
    do_wr(32'h004, 32'h55, 2, 1'b0);
    do_rd(32'h004, 32'h55, 1'b1, 0);
    chk_cnt(2, 1);
    do_wr(32'h004, 32'h99, 1, 1'b1);
    do_rd(32'h004, 32'h99, 1'b1, 0);
    chk_cnt(3, 1);

    // Stray ack while idle is ignored.
    mem_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_req", {31'b0, mem_req}, 0);
    chk("idle_ack_stall", {31'b0, stall}, 0);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    do_rd(32'h004, 32'h99, 1'b1, 0);
    chk_cnt(4, 1);

    // Write miss: no allocate.
    do_wr(32'h008, 32'h77, 1, 1'b0);
    do_rd(32'h008, 32'h77, 1'b0, 2);
    chk_cnt(5, 2);

    // Reset during the second RD_MISS cycle.
    do_reset(1'b0);
    addr = 32'h100; rd_en = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rdmiss_req_pre_rst", {31'b0, mem_req}, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk("abandon_req", {31'b0, mem_req}, 0);
    chk("abandon_stall", {31'b0, stall}, 0);
    chk_cnt(0, 0);
    @(posedge clk);
    #1;
    do_rd(32'h100, 32'hCAFE_F00D, 1'b0, 2);
    chk_cnt(1, 1);

    // Counter saturation at 4 bits.
    do_reset(1'b0);
    do_rd(32'h00C, 32'h1234, 1'b0, 1);
    for (int i = 0; i < 20; i++) begin
      do_rd(32'h00C, 32'h1234, 1'b1, 0);
      if (i == 12) chk("hit_cnt_pre_sat", {28'b0, hit_cnt}, 14);
    end
    chk_cnt(15, 1);

    chk("rdata_queue_drained", rq.size(), 0);
    chk("mem_queue_drained", mq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
